// File: rtl/traffic_pkg.sv
// Shared constants and jam-state encoding for the lane-queue sensor model.
// Module defaults come from here so every lane agrees on thresholds.
package traffic_pkg;

    localparam int NUM_LANES         = 4;
    localparam int DEF_CNT_W         = 4;
    localparam int DEF_MAX_COUNT     = 15;
    localparam int DEF_JAM_ON        = 8;
    localparam int DEF_JAM_OFF       = 3;
    localparam int DEF_DEPART_CYCLES = 4;

    typedef enum logic {
        CLEAR  = 1'b0,
        JAMMED = 1'b1
    } jam_state_e;

endpackage

// File: rtl/lane_queue_monitor.sv
// One lane: arrival edge detect, departure pacing timer, saturating queue
// counter and a two-state jam FSM with hysteresis.
module lane_queue_monitor
    import traffic_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int MAX_COUNT     = DEF_MAX_COUNT,
    parameter int JAM_ON        = DEF_JAM_ON,
    parameter int JAM_OFF       = DEF_JAM_OFF,
    parameter int DEPART_CYCLES = DEF_DEPART_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             car_arrive_i,
    input  logic             allow_i,
    output logic             jam_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int TMR_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(DEPART_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] CNT_ON    = CNT_W'(JAM_ON);
    localparam logic [CNT_W-1:0] CNT_OFF   = CNT_W'(JAM_OFF);

    logic             arrive_q;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    jam_state_e       state_q, state_d;

    logic arrival;
    logic busy;
    logic depart;

    assign arrival = car_arrive_i & ~arrive_q;
    assign busy    = allow_i && (cnt_q != '0);
    assign depart  = busy && (timer_q == TMR_LAST);

    // Any cycle without permission or vehicles throws away the partial interval.
    always_comb begin
        timer_d = '0;
        if (busy && !depart) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (arrival && !depart) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (depart && !arrival) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Hysteresis is judged on the next count so jam moves with the count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (cnt_d >= CNT_ON)  state_d = JAMMED;
            JAMMED:  if (cnt_d <= CNT_OFF) state_d = CLEAR;
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arrive_q <= 1'b0;
            timer_q  <= '0;
            cnt_q    <= '0;
            state_q  <= CLEAR;
        end else begin
            arrive_q <= car_arrive_i;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

    assign cnt_o = cnt_q;
    assign jam_o = (state_q == JAMMED);

endmodule

// File: rtl/traffic_jam_sensor.sv
// Four independent lane monitors feeding jam flags to the traffic controller.
// This level only packs the per-lane ports into vectors and back.
module traffic_jam_sensor
    import traffic_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int MAX_COUNT     = DEF_MAX_COUNT,
    parameter int JAM_ON        = DEF_JAM_ON,
    parameter int JAM_OFF       = DEF_JAM_OFF,
    parameter int DEPART_CYCLES = DEF_DEPART_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             car_arrive_0,
    input  logic             car_arrive_1,
    input  logic             car_arrive_2,
    input  logic             car_arrive_3,
    input  logic             allow_0,
    input  logic             allow_1,
    input  logic             allow_2,
    input  logic             allow_3,
    output logic             jam_sensor_0,
    output logic             jam_sensor_1,
    output logic             jam_sensor_2,
    output logic             jam_sensor_3,
    output logic [CNT_W-1:0] queue_cnt_0,
    output logic [CNT_W-1:0] queue_cnt_1,
    output logic [CNT_W-1:0] queue_cnt_2,
    output logic [CNT_W-1:0] queue_cnt_3
);

    logic [NUM_LANES-1:0] arrive_w;
    logic [NUM_LANES-1:0] allow_w;
    logic [NUM_LANES-1:0] jam_w;
    logic [CNT_W-1:0]     cnt_w [NUM_LANES];

    assign arrive_w = {car_arrive_3, car_arrive_2, car_arrive_1, car_arrive_0};
    assign allow_w  = {allow_3, allow_2, allow_1, allow_0};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        lane_queue_monitor #(
            .CNT_W         (CNT_W),
            .MAX_COUNT     (MAX_COUNT),
            .JAM_ON        (JAM_ON),
            .JAM_OFF       (JAM_OFF),
            .DEPART_CYCLES (DEPART_CYCLES)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .car_arrive_i (arrive_w[l]),
            .allow_i      (allow_w[l]),
            .jam_o        (jam_w[l]),
            .cnt_o        (cnt_w[l])
        );
    end

    assign jam_sensor_0 = jam_w[0];
    assign jam_sensor_1 = jam_w[1];
    assign jam_sensor_2 = jam_w[2];
    assign jam_sensor_3 = jam_w[3];

    assign queue_cnt_0 = cnt_w[0];
    assign queue_cnt_1 = cnt_w[1];
    assign queue_cnt_2 = cnt_w[2];
    assign queue_cnt_3 = cnt_w[3];

endmodule

// File: tb/tb_traffic_jam_sensor.sv
// Directed bench for traffic_jam_sensor: reset, fill, drain, saturation,
// coincident arrival/departure and four-lane independence.
module tb_traffic_jam_sensor;

    logic       clk;
    logic       rst;
    logic [3:0] car;
    logic [3:0] allow;
    logic       jam [4];
    logic [3:0] qc  [4];

    int errors;
    int checks;

    traffic_jam_sensor dut (
        .clk          (clk),
        .rst          (rst),
        .car_arrive_0 (car[0]),
        .car_arrive_1 (car[1]),
        .car_arrive_2 (car[2]),
        .car_arrive_3 (car[3]),
        .allow_0      (allow[0]),
        .allow_1      (allow[1]),
        .allow_2      (allow[2]),
        .allow_3      (allow[3]),
        .jam_sensor_0 (jam[0]),
        .jam_sensor_1 (jam[1]),
        .jam_sensor_2 (jam[2]),
        .jam_sensor_3 (jam[3]),
        .queue_cnt_0  (qc[0]),
        .queue_cnt_1  (qc[1]),
        .queue_cnt_2  (qc[2]),
        .queue_cnt_3  (qc[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int lane);
        car[lane] = 1'b1;
        tick();
        car[lane] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        for (int k = 0; k < 10; k++) pulse(0);
        checks++;
        if (qc[0] !== 4'd10 || jam[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_preload: cnt=%0d jam=%0b expected cnt=10 jam=1", qc[0], jam[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (qc[0] !== 4'd0 || jam[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: cnt=%0d jam=%0b expected cnt=0 jam=0", qc[0], jam[0]);
        end
        #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int l = 0; l < 4; l++) begin
                checks++;
                if (qc[l] !== 4'd0 || jam[l] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_idle lane%0d: cnt=%0d jam=%0b expected 0/0", l, qc[l], jam[l]);
                end
            end
        end
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 8; k++) begin
            car[0] = 1'b1;
            tick();
            checks++;
            if (qc[0] !== 4'(k) || jam[0] !== (k >= 8)) begin
                errors++;
                $display("FAIL fill_step%0d: cnt=%0d jam=%0b expected cnt=%0d jam=%0b",
                         k, qc[0], jam[0], k, (k >= 8));
            end
            car[0] = 1'b0;
            tick();
            checks++;
            if (qc[0] !== 4'(k)) begin
                errors++;
                $display("FAIL fill_hold%0d: cnt=%0d expected %0d", k, qc[0], k);
            end
        end
        for (int l = 1; l < 4; l++) begin
            checks++;
            if (qc[l] !== 4'd0 || jam[l] !== 1'b0) begin
                errors++;
                $display("FAIL fill_other lane%0d: cnt=%0d jam=%0b expected 0/0", l, qc[l], jam[l]);
            end
        end
    endtask

    task automatic test_drain();
        int exp_cnt;
        allow[0] = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            exp_cnt = 8 - e / 4;
            if (exp_cnt < 0) exp_cnt = 0;
            checks++;
            if (qc[0] !== 4'(exp_cnt) || jam[0] !== (exp_cnt > 3)) begin
                errors++;
                $display("FAIL drain_edge%0d: cnt=%0d jam=%0b expected cnt=%0d jam=%0b",
                         e, qc[0], jam[0], exp_cnt, (exp_cnt > 3));
            end
        end
        allow[0] = 1'b0;
    endtask

    task automatic test_saturation();
        car[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (qc[1] !== 4'd1) begin
                errors++;
                $display("FAIL held_level cyc%0d: cnt=%0d expected 1", c, qc[1]);
            end
        end
        car[1] = 1'b0;
        tick();
        for (int k = 1; k <= 20; k++) begin
            pulse(1);
            checks++;
            if (qc[1] !== 4'((1 + k > 15) ? 15 : 1 + k)) begin
                errors++;
                $display("FAIL sat_pulse%0d: cnt=%0d expected %0d", k, qc[1], (1 + k > 15) ? 15 : 1 + k);
            end
        end
        checks++;
        if (jam[1] !== 1'b1) begin
            errors++;
            $display("FAIL sat_jam: jam=%0b expected 1", jam[1]);
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 5; k++) pulse(2);
        allow[2] = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if (qc[2] !== 4'd5) begin
                errors++;
                $display("FAIL simul_pre%0d: cnt=%0d expected 5", e, qc[2]);
            end
        end
        car[2] = 1'b1;
        tick();
        car[2] = 1'b0;
        checks++;
        if (qc[2] !== 4'd5) begin
            errors++;
            $display("FAIL simul_both: cnt=%0d expected 5", qc[2]);
        end
        tick();
        tick();
        allow[2] = 1'b0;
        tick();
        allow[2] = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if (qc[2] !== 4'((e == 4) ? 4 : 5)) begin
                errors++;
                $display("FAIL reassert_edge%0d: cnt=%0d expected %0d", e, qc[2], (e == 4) ? 4 : 5);
            end
        end
        allow[2] = 1'b0;
        checks++;
        if (jam[2] !== 1'b0) begin
            errors++;
            $display("FAIL simul_jam: jam=%0b expected 0", jam[2]);
        end
    endtask

    task automatic test_independence();
        logic [15:0] pat [4];
        bit          m_arr [4];
        int          m_tmr [4];
        int          m_cnt [4];
        bit          m_jam [4];
        bit          a, busy, d;

        pat[0] = 16'b0101_0101_0101_0101;
        pat[1] = 16'b0011_0000_1100_0110;
        pat[2] = 16'b1010_0010_0100_1001;
        pat[3] = 16'b0001_0001_0001_0001;

        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int l = 0; l < 4; l++) begin
            m_arr[l] = 1'b0;
            m_tmr[l] = 0;
            m_cnt[l] = 0;
            m_jam[l] = 1'b0;
        end

        for (int cyc = 0; cyc < 160; cyc++) begin
            for (int l = 0; l < 4; l++) car[l] = pat[l][cyc % 16];
            allow[0] = 1'b1;
            allow[1] = ((cyc / 16) % 2) == 1;
            allow[2] = (cyc % 7) < 4;
            allow[3] = 1'b0;

            for (int l = 0; l < 4; l++) begin
                a    = car[l] && !m_arr[l];
                busy = allow[l] && (m_cnt[l] > 0);
                d    = busy && (m_tmr[l] == 3);
                m_tmr[l] = (busy && !d) ? m_tmr[l] + 1 : 0;
                if (a && !d && m_cnt[l] < 15) m_cnt[l]++;
                else if (d && !a) m_cnt[l]--;
                if (!m_jam[l] && m_cnt[l] >= 8) m_jam[l] = 1'b1;
                else if (m_jam[l] && m_cnt[l] <= 3) m_jam[l] = 1'b0;
                m_arr[l] = car[l];
            end

            tick();
            for (int l = 0; l < 4; l++) begin
                checks++;
                if (qc[l] !== 4'(m_cnt[l]) || jam[l] !== m_jam[l]) begin
                    errors++;
                    $display("FAIL indep cyc%0d lane%0d: cnt=%0d jam=%0b expected cnt=%0d jam=%0b",
                             cyc, l, qc[l], jam[l], m_cnt[l], m_jam[l]);
                end
            end
        end
        car   = 4'b0;
        allow = 4'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        car    = 4'b0;
        allow  = 4'b0;
        #12;
        rst = 1'b0;
        tick();

        test_reset();
        test_fill();
        test_drain();
        test_saturation();
        test_simultaneous();
        test_independence();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
